nspi_frame_sched: RTL

Frame scheduler that sequences the multi-channel SPI transmitter (`nspi_tx`) for the LED-matrix chain. On a frame request it walks a frame buffer word by word. For each word it fetches `CHANNEL_NUMBER` bytes in parallel, loads them into the transmitter, starts the transfer and waits for completion. After the last word it holds the SPI bus idle for a latch gap so the ch32v003 matrices detect the frame boundary. It sits between the HDMI frame-buffer read port and `nspi_tx`.

---
 rtl/nspi_frame_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/nspi_frame_sched.sv
// nspi_frame_sched -- frame scheduler in front of the multi-channel SPI
// transmitter (nspi_tx) driving the LED-matrix chain.
//
// On a frame request it walks the frame buffer word by word: read one word
// (CHANNEL_NUMBER bytes side by side), latch it into tx_data, pulse
// tx_start and wait for tx_finish. After the last word the SPI bus is held
// idle for GAP_CYCLES clocks so the matrices see the frame boundary, then
// frame_done pulses. One extra request arriving mid-frame is remembered and
// runs straight after the current frame.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   frame_start       frame request (pulse or level)
//   busy, frame_done  status: busy until end of frame, done pulse
//   rd_en, rd_addr    frame-buffer read port (data returns 1 cycle later)
//   rd_data           buffer word, channel k at [k*SPI_SIZE +: SPI_SIZE]
//   tx_start          one-cycle start to nspi_tx
//   tx_finish         one-cycle completion from nspi_tx
//   tx_data           registered word to nspi_tx, same packing as rd_data

// Per-channel byte holding register; reloaded only in LATCH so the byte
// stays stable across the transfer and the inter-frame gap.
module nspi_frame_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (ld) q <= d;
    end
endmodule

module nspi_frame_sched #(
    parameter int CHANNEL_NUMBER  = 2,
    parameter int SPI_SIZE        = 8,
    parameter int WORDS_PER_FRAME = 384,
    parameter int GAP_CYCLES      = 64,
    // Floor of 1 keeps a one-word frame legal.
    parameter int ADDR_WIDTH      = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_start,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               rd_en,
    output logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
    output logic                               tx_start,
    input  logic                               tx_finish,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] tx_data
);
    // Gap counter needs at least one bit even when the gap is disabled.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS_PER_FRAME - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_START, S_WAIT_TX, S_GAP, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  idx, idx_nxt;
    logic [GAP_W-1:0]       gap_cnt, gap_cnt_nxt;
    logic                   pend, pend_nxt;

    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] rd_lane, tx_lane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_cnt_nxt;
            pend    <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        gap_cnt_nxt = gap_cnt;
        pend_nxt    = pend;

        // One-deep request memory; a request while already pending is dropped.
        if (frame_start && state != S_IDLE && state != S_DONE)
            pend_nxt = 1'b1;

        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    idx_nxt   = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_START;
            S_START: state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_finish) begin
                    if (idx == LAST_IDX) begin
                        gap_cnt_nxt = '0;
                        state_nxt   = (GAP_CYCLES == 0) ? S_DONE : S_GAP;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt   = S_DONE;
                else                     gap_cnt_nxt = gap_cnt + 1'b1;
            end
            S_DONE: begin
                // A request landing on DONE itself chains like a pending one.
                if (pend || frame_start) begin
                    pend_nxt  = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign rd_lane = rd_data;

    for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_lane
        nspi_frame_lane #(.W(SPI_SIZE)) u_lane (
            .clk (clk),
            .rst (rst),
            .ld  (state == S_LATCH),
            .d   (rd_lane[g]),
            .q   (tx_lane[g])
        );
    end

    // Strobes decode from state only; nothing combinational from the inputs.
    assign tx_data    = tx_lane;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);
    assign rd_en      = (state == S_FETCH);
    assign tx_start   = (state == S_START);
    assign rd_addr    = idx;
endmodule
